gate_net_sequencer: RTL and testbench
=====================================

Name: gate_net_sequencer

Overview:
- Clocked stimulus/response stage wrapped around the two-input, one-output gate-delay network.
- Upstream role: drives `in1`/`in2` through all four input combinations.
- Downstream role: after a programmable settle window, samples the network's `out1`, compares it against an expected truth table, and accumulates pass/fail results.
- Turns the unclocked delay-annotated gate network into a self-checking, cycle-accurate unit under test.

Parameters:
- SETTLE_CYCLES, 4, clock cycles waited per vector before sampling; includes the 2-cycle synchronizer latency; legal minimum 4.
- EXP_VEC, 4'b1111, expected `out1` per vector; bit k is the expected output for {in1,in2}=k.
- CNT_W, 4, width of the settle down-counter; must satisfy 2^CNT_W > SETTLE_CYCLES.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  run request; sampled in IDLE only.
- out1_i  input  1  output of the gate network; asynchronous to clk.
- in1  output  1  stimulus bit (vector index bit 1).
- in2  output  1  stimulus bit (vector index bit 0).
- busy  output  1  high from the start-capturing edge until DONE is left.
- done  output  1  single-cycle pulse at end of sweep.
- resp  output  4  captured `out1` per vector; bit k holds the sample for vector k.
- err_cnt  output  3  number of mismatches vs EXP_VEC; range 0..4.
- glitch_cnt  output  4  late-window transitions observed; see Optional Feature.

Behaviour:
- Reset (async assert, sync-released by the flop fabric): state=IDLE; in1=in2=0; busy=0; done=0; resp=0; err_cnt=0; glitch_cnt=0; idx=0; settle counter=0; both synchronizer flops=0.
- out1_i passes through a 2-flop synchronizer; all sampling and comparison uses the second stage (`out1_s`).
- State machine:
  - IDLE: on start=1, load idx=0, drive {in1,in2}=00, clear resp/err_cnt/glitch_cnt, set cnt=SETTLE_CYCLES-1, busy=1, go SETTLE. start=0 holds IDLE; outputs keep their last results.
  - SETTLE: cnt decrements every cycle; go SAMPLE when cnt==0. Occupies exactly SETTLE_CYCLES cycles.
  - SAMPLE (1 cycle): resp[idx]<=out1_s.
    - If out1_s != EXP_VEC[idx], err_cnt<=err_cnt+1 (cannot exceed 4).
    - If idx==3, go DONE.
    - Otherwise idx<=idx+1, {in1,in2}<=idx+1, cnt<=SETTLE_CYCLES-1, go SETTLE.
  - DONE (1 cycle): done=1, busy=1; next state IDLE with busy=0, done=0.
- Latency: each vector takes SETTLE_CYCLES+1 cycles. DONE is the state during cycle 4*(SETTLE_CYCLES+1)+1 counted from the start edge (cycle 1 = first SETTLE cycle). Default: done high in cycle 21.
- in1/in2 are registered and change only on the edge entering SETTLE; they are stable through SETTLE and SAMPLE.
- Boundary conditions:
  - start asserted while busy: ignored, no restart or queueing.
  - start held high continuously: a new sweep begins in the cycle after done; results are cleared at that restart.
  - rst_n low mid-sweep: immediate return to reset values; partial resp is discarded.
  - SETTLE_CYCLES below 4: unsupported; elaboration-time check issues $error.

Optional Feature:
- Macro: GATE_NET_GLITCH_CHK_EN.
- Defined:
  - During SETTLE, while cnt < SETTLE_CYCLES/2 (late half of the window), each cycle where out1_s differs from its previous-cycle value increments glitch_cnt.
  - glitch_cnt saturates at 15 and is cleared on start.
- Undefined: glitch_cnt is tied to 0 and no extra registers are built.

Test Plan:
- Reset check: rst_n low, then release with start=0 → in1=in2=0, busy=0, done=0, resp=0000, err_cnt=0 held for 10 cycles.
- Pass case: out1_i tied 1, EXP_VEC=1111, single start pulse → in1/in2 step 00,01,10,11 every 5 cycles; done pulses in cycle 21; resp=1111, err_cnt=0, busy drops in cycle 22.
- Failure accounting: out1_i model returns 0 for vectors 01 and 11 → resp=0101, err_cnt=2.
- Busy guard and reset mid-run:
  - start re-pulsed at cycle 8 → ignored; done still occurs exactly once, in cycle 21.
  - rst_n pulsed low at cycle 12 → all outputs return to reset values immediately.
- Continuous start: start held high → back-to-back sweeps, done high in cycles 21 and 42; resp cleared at cycle 22 restart.
- Glitch (macro defined): out1_i toggles 1→0→1 inside the late window of vector 10 → glitch_cnt=2, resp[2]=1, err_cnt=0. Macro undefined → glitch_cnt=0.

Source files
------------

// File: rtl/gate_net_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : gate_net_sequencer
// Brief    : Clocked stimulus/response wrapper around a two-input, one-output
//            gate-delay network. Steps {in1,in2} through 00,01,10,11, waits a
//            programmable settle window per vector, samples the synchronized
//            network output and scores it against an expected truth table.
//            Optional late-window glitch counter: GATE_NET_GLITCH_CHK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module gate_net_sequencer #(
   parameter int         SETTLE_CYCLES = 4,
   parameter logic [3:0] EXP_VEC       = 4'b1111,
   parameter int         CNT_W         = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       out1_i,
   output logic       in1,
   output logic       in2,
   output logic       busy,
   output logic       done,
   output logic [3:0] resp,
   output logic [2:0] err_cnt,
   output logic [3:0] glitch_cnt
);

   // Settle counter reload: the window spans cnt = SETTLE_CYCLES-1 down to 0
   localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'(SETTLE_CYCLES - 1);

   // Elaboration-time legality checks on the configuration
   generate
      if (SETTLE_CYCLES < 4) begin : g_settle_chk
         $error("gate_net_sequencer: SETTLE_CYCLES must be at least 4");
      end
      if ((1 << CNT_W) <= SETTLE_CYCLES) begin : g_cnt_w_chk
         $error("gate_net_sequencer: CNT_W too narrow for SETTLE_CYCLES");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   state_t           r_state;
   logic [1:0]       r_idx;
   logic [CNT_W-1:0] r_cnt;
   logic             r_in1;
   logic             r_in2;
   logic             r_busy;
   logic             r_done;
   logic [3:0]       r_resp;
   logic [2:0]       r_err;
   logic             r_sync1;
   logic             r_sync2;

   logic             w_out1_s;
   logic             w_launch;
   logic [1:0]       w_idx_nxt;

   // A sweep may start from IDLE, or directly from DONE when start is still
   // held, which gives back-to-back sweeps without an idle gap cycle.
   assign w_launch  = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
   assign w_idx_nxt = r_idx + 2'd1;
   assign w_out1_s  = r_sync2;

   // Two-flop synchronizer for the network output, which is asynchronous to clk
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= out1_i;
         r_sync2 <= r_sync1;
      end
   end

   // Sweep sequencer: launch, settle, sample and score each vector, then report
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_idx   <= 2'd0;
         r_cnt   <= '0;
         r_in1   <= 1'b0;
         r_in2   <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_resp  <= 4'd0;
         r_err   <= 3'd0;
      end else begin
         // done is a one-cycle pulse; only the SAMPLE->DONE edge raises it
         r_done <= 1'b0;
         unique case (r_state)
            ST_IDLE, ST_DONE: begin
               if (w_launch) begin
                  r_idx   <= 2'd0;
                  r_in1   <= 1'b0;
                  r_in2   <= 1'b0;
                  r_resp  <= 4'd0;
                  r_err   <= 3'd0;
                  r_cnt   <= c_cnt_load;
                  r_busy  <= 1'b1;
                  r_state <= ST_SETTLE;
               end else begin
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end
            ST_SETTLE: begin
               if (r_cnt == '0) begin
                  r_state <= ST_SAMPLE;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            ST_SAMPLE: begin
               r_resp[r_idx] <= w_out1_s;
               // At most one increment per vector, so four vectors cap it at 4
               if (w_out1_s != EXP_VEC[r_idx]) begin
                  r_err <= r_err + 3'd1;
               end
               if (r_idx == 2'd3) begin
                  r_done  <= 1'b1;
                  r_state <= ST_DONE;
               end else begin
                  r_idx   <= w_idx_nxt;
                  r_in1   <= w_idx_nxt[1];
                  r_in2   <= w_idx_nxt[0];
                  r_cnt   <= c_cnt_load;
                  r_state <= ST_SETTLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef GATE_NET_GLITCH_CHK_EN
   // Late half of the settle window: the output should already be stable here
   localparam logic [CNT_W-1:0] c_late_lim = CNT_W'(SETTLE_CYCLES / 2);

   logic       r_out1_prev;
   logic [3:0] r_glitch;

   // Count output transitions seen late in the settle window, saturating at 15
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out1_prev <= 1'b0;
         r_glitch    <= 4'd0;
      end else begin
         r_out1_prev <= w_out1_s;
         if (w_launch) begin
            r_glitch <= 4'd0;
         end else if ((r_state == ST_SETTLE) && (r_cnt < c_late_lim) &&
                      (w_out1_s != r_out1_prev) && (r_glitch != 4'hF)) begin
            r_glitch <= r_glitch + 4'd1;
         end
      end
   end

   assign glitch_cnt = r_glitch;
`else
   assign glitch_cnt = 4'd0;
`endif

   assign in1     = r_in1;
   assign in2     = r_in2;
   assign busy    = r_busy;
   assign done    = r_done;
   assign resp    = r_resp;
   assign err_cnt = r_err;

endmodule
`default_nettype wire

// File: tb/tb_gate_net_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_gate_net_sequencer
// Brief    : Self-checking bench for gate_net_sequencer. The gate network is
//            modelled as a 4-entry truth table indexed by {in1,in2}; expected
//            results come from sweep-level rules (vector timing, response =
//            table, error count = mismatching table entries).
// Revision : 1.0 - initial release
// ============================================================================
module tb_gate_net_sequencer;

   localparam int         S        = 4;
   localparam logic [3:0] EXP      = 4'b1111;
   localparam int         VEC_LEN  = S + 1;
   localparam int         DONE_CYC = 4 * VEC_LEN + 1;

   logic       clk      = 1'b0;
   logic       rst_n    = 1'b0;
   logic       start    = 1'b0;
   logic [3:0] net_tt   = 4'b1111;
   logic       force_lo = 1'b0;
   logic       out1_i;
   logic       in1;
   logic       in2;
   logic       busy;
   logic       done;
   logic [3:0] resp;
   logic [2:0] err_cnt;
   logic [3:0] glitch_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural gate network: truth table lookup, with an optional forced low
   assign out1_i = force_lo ? 1'b0 : net_tt[{in1, in2}];

   gate_net_sequencer #(
      .SETTLE_CYCLES(S),
      .EXP_VEC      (EXP),
      .CNT_W        (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .out1_i    (out1_i),
      .in1       (in1),
      .in2       (in2),
      .busy      (busy),
      .done      (done),
      .resp      (resp),
      .err_cnt   (err_cnt),
      .glitch_cnt(glitch_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // Advance one clock; land 1 time unit after the rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Vector index expected on {in1,in2} during sweep cycle c (1-based)
   function automatic logic [1:0] exp_vec_at(int c);
      return 2'((c - 1) / VEC_LEN);
   endfunction

   // Number of truth-table entries disagreeing with the expected table
   function automatic logic [2:0] exp_errs(logic [3:0] tt);
      logic [3:0] ev;
      int e;
      ev = EXP;
      e  = 0;
      for (int k = 0; k < 4; k++) begin
         if (tt[k] != ev[k]) e++;
      end
      return 3'(e);
   endfunction

   task automatic test_reset();
      logic [14:0] obs;
      rst_n = 1'b0;
      start = 1'b0;
      #2;
      obs = {in1, in2, busy, done, resp, err_cnt, glitch_cnt};
      n_checks++;
      if (obs !== 15'd0) begin
         n_fail++;
         $display("FAIL reset_low: got %h expected 0", obs);
      end
      repeat (3) tick();
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         obs = {in1, in2, busy, done, resp, err_cnt, glitch_cnt};
         n_checks++;
         if (obs !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_hold cycle %0d: got %h expected 0", i, obs);
         end
      end
   endtask

   task automatic test_pass();
      net_tt = 4'b1111;
      repeat (3) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c <= DONE_CYC + 1; c++) begin
         if (c <= 4 * VEC_LEN) begin
            n_checks++;
            if ({in1, in2} !== exp_vec_at(c)) begin
               n_fail++;
               $display("FAIL pass_vec c=%0d: got %b expected %b", c, {in1, in2}, exp_vec_at(c));
            end
         end
         n_checks++;
         if (done !== (c == DONE_CYC)) begin
            n_fail++;
            $display("FAIL pass_done c=%0d: got %b expected %b", c, done, (c == DONE_CYC));
         end
         n_checks++;
         if (busy !== (c <= DONE_CYC)) begin
            n_fail++;
            $display("FAIL pass_busy c=%0d: got %b expected %b", c, busy, (c <= DONE_CYC));
         end
         if (c == DONE_CYC) begin
            n_checks++;
            if (resp !== net_tt || err_cnt !== exp_errs(net_tt)) begin
               n_fail++;
               $display("FAIL pass_result: got resp=%b err=%0d expected resp=%b err=%0d",
                        resp, err_cnt, net_tt, exp_errs(net_tt));
            end
         end
         tick();
      end
   endtask

   task automatic test_fail_accounting();
      int c;
      net_tt = 4'b0101;
      repeat (2) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      c = 1;
      while (c < 40 && done !== 1'b1) begin
         tick();
         c++;
      end
      n_checks++;
      if (c != DONE_CYC) begin
         n_fail++;
         $display("FAIL fail_done_cycle: got %0d expected %0d", c, DONE_CYC);
      end
      n_checks++;
      if (resp !== net_tt || err_cnt !== exp_errs(net_tt)) begin
         n_fail++;
         $display("FAIL fail_result: got resp=%b err=%0d expected resp=%b err=%0d",
                  resp, err_cnt, net_tt, exp_errs(net_tt));
      end
      tick();
   endtask

   task automatic test_random_tables();
      int c;
      for (int t = 0; t < 8; t++) begin
         net_tt = 4'($urandom);
         repeat (2) tick();
         start = 1'b1;
         tick();
         start = 1'b0;
         c = 1;
         while (c < 40 && done !== 1'b1) begin
            tick();
            c++;
         end
         n_checks++;
         if (c != DONE_CYC) begin
            n_fail++;
            $display("FAIL rand_done_cycle t=%0d: got %0d expected %0d", t, c, DONE_CYC);
         end
         n_checks++;
         if (resp !== net_tt || err_cnt !== exp_errs(net_tt)) begin
            n_fail++;
            $display("FAIL rand_result t=%0d: got resp=%b err=%0d expected resp=%b err=%0d",
                     t, resp, err_cnt, net_tt, exp_errs(net_tt));
         end
`ifndef GATE_NET_GLITCH_CHK_EN
         n_checks++;
         if (glitch_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL rand_glitch t=%0d: got %0d expected 0", t, glitch_cnt);
         end
`endif
         tick();
         n_checks++;
         if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL rand_after t=%0d: got busy=%b done=%b expected 0 0", t, busy, done);
         end
      end
   endtask

   task automatic test_busy_guard();
      int n_done;
      int done_at;
      n_done  = 0;
      done_at = 0;
      net_tt  = 4'($urandom);
      repeat (2) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c <= 30; c++) begin
         if (done === 1'b1) begin
            n_done++;
            done_at = c;
         end
         start = (c == 8);
         tick();
      end
      start = 1'b0;
      n_checks++;
      if (n_done != 1 || done_at != DONE_CYC) begin
         n_fail++;
         $display("FAIL busy_guard: got %0d done pulses last at %0d expected 1 at %0d",
                  n_done, done_at, DONE_CYC);
      end
      n_checks++;
      if (resp !== net_tt) begin
         n_fail++;
         $display("FAIL busy_guard_resp: got %b expected %b", resp, net_tt);
      end
   endtask

   task automatic test_reset_mid();
      logic [14:0] obs;
      net_tt = 4'b1111;
      repeat (2) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (11) tick();
      n_checks++;
      if (busy !== 1'b1 || {in1, in2} !== exp_vec_at(12)) begin
         n_fail++;
         $display("FAIL midrst_pre: got busy=%b vec=%b expected 1 %b", busy, {in1, in2}, exp_vec_at(12));
      end
      rst_n = 1'b0;
      #1;
      obs = {in1, in2, busy, done, resp, err_cnt, glitch_cnt};
      n_checks++;
      if (obs !== 15'd0) begin
         n_fail++;
         $display("FAIL midrst_async: got %h expected 0", obs);
      end
      #2;
      rst_n = 1'b1;
      repeat (3) tick();
      obs = {in1, in2, busy, done, resp, err_cnt, glitch_cnt};
      n_checks++;
      if (obs !== 15'd0) begin
         n_fail++;
         $display("FAIL midrst_after: got %h expected 0", obs);
      end
   endtask

   task automatic test_back_to_back();
      net_tt = 4'($urandom_range(1, 15));
      repeat (2) tick();
      start = 1'b1;
      tick();
      for (int c = 1; c <= 2 * DONE_CYC + 1; c++) begin
         n_checks++;
         if (done !== (c == DONE_CYC || c == 2 * DONE_CYC)) begin
            n_fail++;
            $display("FAIL b2b_done c=%0d: got %b", c, done);
         end
         n_checks++;
         if (busy !== (c <= 2 * DONE_CYC)) begin
            n_fail++;
            $display("FAIL b2b_busy c=%0d: got %b expected %b", c, busy, (c <= 2 * DONE_CYC));
         end
         if (c == DONE_CYC || c == 2 * DONE_CYC) begin
            n_checks++;
            if (resp !== net_tt) begin
               n_fail++;
               $display("FAIL b2b_resp c=%0d: got %b expected %b", c, resp, net_tt);
            end
         end
         if (c == DONE_CYC + 1) begin
            n_checks++;
            if (resp !== 4'd0 || err_cnt !== 3'd0 || {in1, in2} !== 2'b00) begin
               n_fail++;
               $display("FAIL b2b_restart: got resp=%b err=%0d vec=%b expected 0 0 00",
                        resp, err_cnt, {in1, in2});
            end
         end
         if (c == 2 * DONE_CYC) start = 1'b0;
         tick();
      end
      start = 1'b0;
   endtask

   task automatic test_glitch();
      logic [3:0] exp_g;
`ifdef GATE_NET_GLITCH_CHK_EN
      exp_g = 4'd2;
`else
      exp_g = 4'd0;
`endif
      net_tt   = 4'b1111;
      force_lo = 1'b0;
      repeat (4) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      // A one-cycle low pulse in cycle 11 reaches the synchronized output in
      // cycle 13 and recovers in cycle 14: both inside vector 2's late window
      for (int c = 1; c < DONE_CYC; c++) begin
         force_lo = (c == 2 * VEC_LEN + 1);
         tick();
      end
      force_lo = 1'b0;
      n_checks++;
      if (done !== 1'b1 || glitch_cnt !== exp_g) begin
         n_fail++;
         $display("FAIL glitch_cnt: got done=%b glitch=%0d expected 1 %0d", done, glitch_cnt, exp_g);
      end
      n_checks++;
      if (resp !== 4'b1111 || err_cnt !== 3'd0) begin
         n_fail++;
         $display("FAIL glitch_result: got resp=%b err=%0d expected 1111 0", resp, err_cnt);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_pass();
      test_fail_accounting();
      test_random_tables();
      test_busy_guard();
      test_reset_mid();
      test_back_to_back();
      test_glitch();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
